// File: rtl/move_sequencer.sv
// Connect-4 move controller: finds the landing row in a column, writes the piece,
// then walks the four line directions around it to detect a win or a full-board draw.
module move_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] column,
    input  logic [1:0] piece,
    output logic [2:0] rd_row,
    output logic [2:0] rd_col,
    input  logic [1:0] rd_cell,
    output logic       wr_en,
    output logic [2:0] wr_row,
    output logic [2:0] wr_col,
    output logic [1:0] wr_cell,
    output logic       busy,
    output logic       done,
    output logic       illegal,
    output logic       win,
    output logic       draw,
    output logic [1:0] winner,
    output logic [2:0] last_row,
    output logic [5:0] move_count
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        WRITE,
        CHECK,
        WIN,
        RESULT,
        REJECT
    } state_t;

    localparam logic [5:0] CellsTotal = 6'd42;

    // A "sense" index packs direction in bits [2:1] (horizontal, vertical, diagonal,
    // anti-diagonal) and polarity in bit 0 (0 = plus, 1 = minus).
    function automatic logic signed [4:0] stepRow(input logic [2:0] row, input logic [2:0] sense,
                                                  input logic [1:0] k);
        logic signed [4:0] dr;
        dr = (sense[2:1] == 2'd0) ? 5'sd0 : 5'sd1;
        if (sense[0]) dr = -dr;
        return $signed({2'b00, row}) + $signed({3'b000, k}) * dr;
    endfunction

    function automatic logic signed [4:0] stepCol(input logic [2:0] col, input logic [2:0] sense,
                                                  input logic [1:0] k);
        logic signed [4:0] dc;
        case (sense[2:1])
            2'd0:    dc = 5'sd1;
            2'd1:    dc = 5'sd0;
            2'd2:    dc = 5'sd1;
            default: dc = -5'sd1;
        endcase
        if (sense[0]) dc = -dc;
        return $signed({2'b00, col}) + $signed({3'b000, k}) * dc;
    endfunction

    function automatic logic inBoard(input logic signed [4:0] r, input logic signed [4:0] c);
        return (r >= 5'sd0) && (r <= 5'sd5) && (c >= 5'sd0) && (c <= 5'sd6);
    endfunction

    // First sense at or after 'from' whose first step lands on the board; skipping
    // whole senses here is what lets off-board steps cost no cycle.
    function automatic logic [3:0] findSense(input logic [2:0] row, input logic [2:0] col,
                                             input logic [3:0] from);
        logic       found;
        logic [2:0] s;
        found = 1'b0;
        s     = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!found && (4'(i) >= from) &&
                inBoard(stepRow(row, 3'(i), 2'd1), stepCol(col, 3'(i), 2'd1))) begin
                found = 1'b1;
                s     = 3'(i);
            end
        end
        return {found, s};
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        col_q, col_d;
    logic [1:0]        piece_q, piece_d;
    logic [2:0]        row_q, row_d;
    logic [2:0]        sense_q, sense_d;
    logic [1:0]        k_q, k_d;
    logic [2:0]        runCount_q, runCount_d;
    logic              win_q, win_d;
    logic              draw_q, draw_d;
    logic [1:0]        winner_q, winner_d;
    logic [2:0]        lastRow_q, lastRow_d;
    logic [5:0]        moveCount_q, moveCount_d;

    logic signed [4:0] curRow, curCol;
    logic              nextSameOk;
    logic [3:0]        firstSense, nextSense;
    logic              match;
    logic              advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= 3'd0;
            piece_q     <= 2'd0;
            row_q       <= 3'd0;
            sense_q     <= 3'd0;
            k_q         <= 2'd0;
            runCount_q  <= 3'd0;
            win_q       <= 1'b0;
            draw_q      <= 1'b0;
            winner_q    <= 2'd0;
            lastRow_q   <= 3'd0;
            moveCount_q <= 6'd0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            piece_q     <= piece_d;
            row_q       <= row_d;
            sense_q     <= sense_d;
            k_q         <= k_d;
            runCount_q  <= runCount_d;
            win_q       <= win_d;
            draw_q      <= draw_d;
            winner_q    <= winner_d;
            lastRow_q   <= lastRow_d;
            moveCount_q <= moveCount_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        piece_d     = piece_q;
        row_d       = row_q;
        sense_d     = sense_q;
        k_d         = k_q;
        runCount_d  = runCount_q;
        win_d       = win_q;
        draw_d      = draw_q;
        winner_d    = winner_q;
        lastRow_d   = lastRow_q;
        moveCount_d = moveCount_q;
        rd_row      = 3'd0;
        rd_col      = 3'd0;
        wr_en       = 1'b0;
        wr_row      = 3'd0;
        wr_col      = 3'd0;
        wr_cell     = 2'd0;
        done        = 1'b0;
        illegal     = 1'b0;
        advance     = 1'b0;

        curRow     = stepRow(row_q, sense_q, k_q);
        curCol     = stepCol(col_q, sense_q, k_q);
        nextSameOk = (k_q != 2'd3) &&
                     inBoard(stepRow(row_q, sense_q, k_q + 2'd1), stepCol(col_q, sense_q, k_q + 2'd1));
        firstSense = findSense(row_q, col_q, 4'd0);
        nextSense  = findSense(row_q, col_q, {1'b0, sense_q} + 4'd1);
        match      = inBoard(curRow, curCol) && (rd_cell == piece_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    col_d   = column;
                    piece_d = piece;
                    if (column > 3'd6 || piece == 2'b00 || piece == 2'b11 || win_q || draw_q) begin
                        state_d = REJECT;
                    end else begin
                        row_d   = 3'd5;
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                rd_row = row_q;
                rd_col = col_q;
                if (rd_cell == 2'b00) begin
                    state_d = WRITE;
                end else if (row_q == 3'd0) begin
                    state_d = REJECT;
                end else begin
                    row_d = row_q - 3'd1;
                end
            end
            WRITE: begin
                wr_en       = 1'b1;
                wr_row      = row_q;
                wr_col      = col_q;
                wr_cell     = piece_q;
                moveCount_d = (moveCount_q == CellsTotal) ? moveCount_q : moveCount_q + 6'd1;
                lastRow_d   = row_q;
                runCount_d  = 3'd1;
                if (firstSense[3]) begin
                    sense_d = firstSense[2:0];
                    k_d     = 2'd1;
                    state_d = CHECK;
                end else begin
                    if (moveCount_d == CellsTotal) draw_d = 1'b1;
                    state_d = RESULT;
                end
            end
            CHECK: begin
                rd_row = curRow[2:0];
                rd_col = curCol[2:0];
                if (match) begin
                    runCount_d = runCount_q + 3'd1;
                    if (runCount_q == 3'd3) begin
                        state_d = WIN;
                    end else if (nextSameOk) begin
                        k_d = k_q + 2'd1;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    advance = 1'b1;
                end
                // The run count carries from the plus sense into the minus sense of the
                // same line and restarts only when the direction changes.
                if (advance) begin
                    if (nextSense[3]) begin
                        sense_d = nextSense[2:0];
                        k_d     = 2'd1;
                        if (nextSense[2:1] != sense_q[2:1]) runCount_d = 3'd1;
                    end else begin
                        if (moveCount_q == CellsTotal) draw_d = 1'b1;
                        state_d = RESULT;
                    end
                end
            end
            WIN: begin
                win_d    = 1'b1;
                winner_d = piece_q;
                state_d  = RESULT;
            end
            RESULT: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            REJECT: begin
                illegal = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign win        = win_q;
    assign draw       = draw_q;
    assign winner     = winner_q;
    assign last_row   = lastRow_q;
    assign move_count = moveCount_q;

endmodule
